// File: rtl/demux24b_pkg.sv
// Shared constants and types for the demux24b stream demultiplexer.
//   CH_A / CH_B : values of the per-word channel select `s`
//   W_DEFAULT   : default data width
//   CNT_W       : width of the per-channel delivery counters
package demux24b_pkg;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  localparam int W_DEFAULT = 4;
  localparam int CNT_W     = 8;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/demux24b_fifo.sv
// Small synchronous FIFO used as the per-channel buffer of demux24b_stream.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (empties the FIFO)
//   wdata, push   : write port; push is ignored while full
//   rdata, pop    : head word (from storage, no bypass); pop ignored while empty
//   full, empty   : occupancy flags
module demux24b_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] wdata,
  input  logic         push,
  output logic [W-1:0] rdata,
  input  logic         pop,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is read straight from the storage array, so a word written this
  // edge becomes visible only after it, never on the same cycle.
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux24b_stream.sv
// Stream demultiplexer: routes each input word to channel A (s=0) or B (s=1),
// each channel buffered by its own FIFO so one stalled sink does not block
// words already queued for the other.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   in_data, s, in_valid        : producer word, channel select, valid
//   in_ready                    : selected channel has room (not gated by in_valid)
//   a_data, a_valid, a_ready    : channel A output handshake
//   b_data, b_valid, b_ready    : channel B output handshake
//   a_count, b_count            : words delivered per channel, mod 256
module demux24b_stream
  import demux24b_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic             s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [W-1:0]     b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  logic full_a, empty_a, push_a, pop_a;
  logic full_b, empty_b, push_b, pop_b;
  logic accept;

  // Head-of-line: only the selected channel's fullness matters.
  assign in_ready = !rst && !((s == CH_B) ? full_b : full_a);
  assign accept   = in_valid && in_ready;
  assign push_a   = accept && (s == CH_A);
  assign push_b   = accept && (s == CH_B);

  assign a_valid = !empty_a;
  assign b_valid = !empty_b;
  assign pop_a   = a_valid && a_ready;
  assign pop_b   = b_valid && b_ready;

  demux24b_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .wdata (in_data),
    .push  (push_a),
    .rdata (a_data),
    .pop   (pop_a),
    .full  (full_a),
    .empty (empty_a)
  );

  demux24b_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .wdata (in_data),
    .push  (push_b),
    .rdata (b_data),
    .pop   (pop_b),
    .full  (full_b),
    .empty (empty_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_count <= '0;
      b_count <= '0;
    end else begin
      if (pop_a) begin
        a_count <= a_count + cnt_t'(1);
      end
      if (pop_b) begin
        b_count <= b_count + cnt_t'(1);
      end
    end
  end

endmodule
